// File: rtl/new_rev_pkg.sv
// Shared constants and next-value arithmetic for the new_rev up/down counter.
// Saturation is chosen at build time by NEW_REV_SAT_EN (see new_rev_next).
package new_rev_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Widest counter the helper function can represent; callers truncate the result.
    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] next_count(
        input logic [MAX_W-1:0] cur,
        input logic             dir,
        input logic             sat,
        input int unsigned      width = 4
    );
        logic [MAX_W-1:0] top_val;
        top_val = {MAX_W{1'b1}} >> (MAX_W - width);
        if (dir == DIR_UP) begin
            if (cur == top_val) begin
                next_count = sat ? top_val : '0;
            end else begin
                next_count = cur + MAX_W'(1);
            end
        end else begin
            if (cur == '0) begin
                next_count = sat ? '0 : top_val;
            end else begin
                next_count = cur - MAX_W'(1);
            end
        end
    endfunction

endpackage

// File: rtl/new_rev_next.sv
// Combinational next-count logic: increment or decrement with wrap-around,
// or with clamping at the ends when NEW_REV_SAT_EN is defined.
module new_rev_next
    import new_rev_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             dir,
    output logic [WIDTH-1:0] nxt
);

`ifdef NEW_REV_SAT_EN
    localparam logic SAT_MODE = 1'b1;
`else
    localparam logic SAT_MODE = 1'b0;
`endif

    assign nxt = WIDTH'(next_count(MAX_W'(cur), dir, SAT_MODE, WIDTH));

endmodule

// File: rtl/new_rev.sv
// WIDTH-bit up/down counter with count enable; d_out is the count register itself.
// Define NEW_REV_SAT_EN to clamp at 0 / 2^WIDTH-1 instead of wrapping.
module new_rev
    import new_rev_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             ctr_i,
    output logic [WIDTH-1:0] d_out
);

    // Power-up value makes the first cycles defined even without a reset pulse.
    logic [WIDTH-1:0] count_reg = RST_VAL;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] step_val;

    new_rev_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .cur (count_reg),
        .dir (ctr_i),
        .nxt (step_val)
    );

    always_comb begin
        count_next = count_reg;
        if (ce_i) begin
            count_next = step_val;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_reg <= RST_VAL;
        end else begin
            count_reg <= count_next;
        end
    end

    assign d_out = count_reg;

endmodule

// File: tb/tb_new_rev.sv
// Self-checking bench for new_rev (WIDTH=4, RST_VAL=0): directed vector table,
// a hand-written reversal sequence and random stimulus against an arithmetic model.
module tb_new_rev;

    localparam int W = 4;
    localparam int MODV = 16;

`ifdef NEW_REV_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         ce_i  = 1'b0;
    logic         ctr_i = 1'b0;
    logic [W-1:0] d_out;

    int tests  = 0;
    int failed = 0;
    int model  = 0;

    typedef struct {
        bit         rst;
        bit         ce;
        bit         ctr;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    new_rev #(
        .WIDTH   (W),
        .RST_VAL (4'h0)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ce_i  (ce_i),
        .ctr_i (ctr_i),
        .d_out (d_out)
    );

    always #5 clk_i = ~clk_i;

    // Reference: the count as a plain integer in 0..15, updated from the priority rules.
    function automatic int model_next(input int cur, input bit rst, input bit ce, input bit up);
        if (rst) return 0;
        if (!ce) return cur;
        if (up) return SAT ? ((cur + 1 > MODV - 1) ? MODV - 1 : cur + 1) : (cur + 1) % MODV;
        return SAT ? ((cur - 1 < 0) ? 0 : cur - 1) : (cur + MODV - 1) % MODV;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: d_out=%h expected=%h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: d_out=%h", name, act);
        end
    endtask

    // Apply one set of inputs across one rising edge, then sample 1 ns later.
    task automatic step(input bit rst, input bit ce, input bit ctr);
        rst_i = rst;
        ce_i  = ce;
        ctr_i = ctr;
        @(posedge clk_i);
        #1;
        model = model_next(model, rst, ce, ctr);
    endtask

    task automatic add(input bit rst, input bit ce, input bit ctr, input logic [3:0] exp, input string name);
        vec_t v;
        v.rst = rst; v.ce = ce; v.ctr = ctr; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        // Directed table, continuing from the power-up run (count 4 wrap / F sat).
        add(1, 1, 1, 4'h0, "rst_first_edge");
        add(1, 1, 1, 4'h0, "rst_second_edge");
        for (int i = 1; i <= 10; i++) add(0, 1, 1, 4'(i), "up_after_rst");
        for (int i = 0; i < 5; i++) add(0, 0, 1'(i % 2), 4'hA, "hold_ce0");
        for (int i = 11; i <= 15; i++) add(0, 1, 1, 4'(i), "up_to_f");
        add(1, 0, 0, 4'h0, "rst_ce0");
        add(0, 1, 1, 4'h1, "up_to_2");
        add(0, 1, 1, 4'h2, "up_to_2");
        add(0, 1, 0, 4'h1, "down_from_2");
        add(0, 1, 0, 4'h0, "down_to_0");
`ifdef NEW_REV_SAT_EN
        add(0, 1, 0, 4'h0, "down_sat_0");
        add(0, 1, 0, 4'h0, "down_sat_0b");
`else
        add(0, 1, 0, 4'hF, "down_wrap_f");
        add(0, 1, 0, 4'hE, "down_wrap_e");
`endif
        add(1, 1, 0, 4'h0, "rst_dir_down");
        for (int i = 1; i <= 7; i++) add(0, 1, 1, 4'(i), "up_to_7");
        add(0, 1, 1, 4'h8, "flip_up");
        add(0, 1, 0, 4'h7, "flip_down");
        add(0, 1, 1, 4'h8, "up_to_9");
        add(0, 1, 1, 4'h9, "up_to_9");
        add(1, 1, 1, 4'h0, "rst_and_ce_from_9");
        for (int i = 1; i <= 14; i++) add(0, 1, 1, 4'(i), "up_to_e");
`ifdef NEW_REV_SAT_EN
        add(0, 1, 1, 4'hF, "sat_up_f");
        add(0, 1, 1, 4'hF, "sat_hold_f");
        add(0, 1, 1, 4'hF, "sat_hold_f2");
`else
        add(0, 1, 1, 4'hF, "wrap_up_f");
        add(0, 1, 1, 4'h0, "wrap_up_0");
        add(0, 1, 1, 4'h1, "wrap_up_1");
`endif

        // Power-up value without any reset pulse.
        #1;
        check("powerup", d_out, W'(model));

        // 20 up edges from power-up, passing the top of the range.
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1);
            check($sformatf("powerup_up_%0d", i + 1), d_out, W'(model));
        end
        check("powerup_20_edges", d_out, SAT ? 4'hF : 4'h4);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ce, vecs[i].ctr);
            check(vecs[i].name, d_out, vecs[i].exp);
        end

        // Reversal every edge from 5: 6,5,6,5 with no dead cycle.
        step(1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1);
        check("rev_start_5", d_out, 4'h5);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1'(i % 2 == 0));
            check($sformatf("rev_%0d", i), d_out, (i % 2 == 0) ? 4'h6 : 4'h5);
        end

        // Random stimulus against the model.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 1'($urandom));
            check($sformatf("rand_%0d r%0b c%0b d%0b", i, rst_i, ce_i, ctr_i), d_out, W'(model));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
